// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and data-memory waits.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int LD_STALL_CYCLES = 1,
  parameter int BR_FLUSH_CYCLES = 2,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_hold,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    BR_FLUSH = 2'b01,
    LD_STALL = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mem_stall, load_use, illegal;

  assign mem_stall = mem_req & ~mem_ack;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    illegal      = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    case (state)
      RUN, LD_STALL: begin
        // A taken branch squashes the ID instruction, so it overrides any stall.
        if (ex_br_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (BR_FLUSH_CYCLES > 1) begin
            state_next = BR_FLUSH;
            cnt_next   = CNT_W'(BR_FLUSH_CYCLES - 1);
          end else begin
            state_next = RUN;
            cnt_next   = '0;
          end
        end else if (state == LD_STALL) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_next     = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_next = RUN;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (LD_STALL_CYCLES > 1) begin
            state_next = LD_STALL;
            cnt_next   = CNT_W'(LD_STALL_CYCLES - 1);
          end
        end
      end
      BR_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        cnt_next     = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_next = RUN;
      end
      default: begin
        illegal    = 1'b1;
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase

    // Memory wait freezes the whole sequencer; EX re-presents its events after release.
    if (mem_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_hold  = 1'b1;
      if (!illegal) begin
        state_next = state;
        cnt_next   = cnt;
      end
    end

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_hold  = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic        br_accept;
  logic [31:0] stall_cnt, flush_cnt;

  assign br_accept = ~rst & ~mem_stall & ex_br_taken & ((state == RUN) | (state == LD_STALL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) stall_cnt <= stall_cnt + 32'd1;
      if (br_accept) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_stall = stall_cnt;
  assign perf_flush = flush_cnt;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two parameterisations driven by shared random and directed stimulus,
// checked every cycle against a remaining-cycle-count model of the sequencing rules.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_br_taken = 0;
  logic        mem_req = 0, mem_ack = 0;

  logic        a_pcw, a_ifw, a_flush, a_bub, a_hold;
  logic        b_pcw, b_ifw, b_flush, b_bub, b_hold;
  logic [31:0] a_ps, a_pf, b_ps, b_pf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LD_STALL_CYCLES(1), .BR_FLUSH_CYCLES(2), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_flush),
    .id_ex_bubble(a_bub), .ex_mem_hold(a_hold),
    .perf_stall(a_ps), .perf_flush(a_pf)
  );

  hazard_ctrl #(.LD_STALL_CYCLES(3), .BR_FLUSH_CYCLES(3), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_flush),
    .id_ex_bubble(b_bub), .ex_mem_hold(b_hold),
    .perf_stall(b_ps), .perf_flush(b_pf)
  );

  // Output bundle order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold}
  logic [4:0]  got [2];
  logic [31:0] gps [2];
  logic [31:0] gpf [2];
  assign got[0] = {a_pcw, a_ifw, a_flush, a_bub, a_hold};
  assign got[1] = {b_pcw, b_ifw, b_flush, b_bub, b_hold};
  assign gps[0] = a_ps;
  assign gps[1] = b_ps;
  assign gpf[0] = a_pf;
  assign gpf[1] = b_pf;

  // Model: remaining extra stall / flush cycles per instance, plus event tallies.
  int          ld_p [2] = '{1, 3};
  int          br_p [2] = '{2, 3};
  int          ld_left [2] = '{0, 0};
  int          br_left [2] = '{0, 0};
  int unsigned m_stall [2] = '{0, 0};
  int unsigned m_flush [2] = '{0, 0};

  always @(negedge clk) begin
    logic       lu, inc_s, inc_f;
    logic [4:0] e;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    for (int i = 0; i < 2; i++) begin
      inc_f = 1'b0;
      if (rst) begin
        ld_left[i] = 0; br_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        e = 5'b00110;
      end else if (mem_req && !mem_ack) begin
        e = 5'b00001;
      end else if (br_left[i] > 0) begin
        e = 5'b11110;
        br_left[i]--;
      end else if (ex_br_taken) begin
        e = 5'b11110;
        br_left[i] = br_p[i] - 1;
        ld_left[i] = 0;
        inc_f = 1'b1;
      end else if (ld_left[i] > 0) begin
        e = 5'b00010;
        ld_left[i]--;
      end else if (lu) begin
        e = 5'b00010;
        ld_left[i] = ld_p[i] - 1;
      end else begin
        e = 5'b11000;
      end
      inc_s = !rst && !e[4];

      checks++;
      if (got[i] !== e) begin
        errors++;
        $display("FAIL ctrl%0d t=%0t got=%b exp=%b", i, $time, got[i], e);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (gps[i] !== m_stall[i]) begin
        errors++;
        $display("FAIL perf_stall%0d t=%0t got=%0d exp=%0d", i, $time, gps[i], m_stall[i]);
      end
      checks++;
      if (gpf[i] !== m_flush[i]) begin
        errors++;
        $display("FAIL perf_flush%0d t=%0t got=%0d exp=%0d", i, $time, gpf[i], m_flush[i]);
      end
`else
      checks++;
      if (gps[i] !== 32'd0 || gpf[i] !== 32'd0) begin
        errors++;
        $display("FAIL perf_tied%0d t=%0t got=%0d/%0d exp=0/0", i, $time, gps[i], gpf[i]);
      end
`endif
      if (inc_s) m_stall[i]++;
      if (inc_f) m_flush[i]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, g, e);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_br_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic ld_hazard();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    chk("reset_out", 32'(got[0]), 32'b00110);
    next(); rst = 0;

    // Load-use, then the load moves on
    ld_hazard();                         @(negedge clk); chk("load_use", 32'(got[0]), 32'b00010);
    next(); idle();                      @(negedge clk); chk("lu_release", 32'(got[0]), 32'b11000);

    // x0 and unused source never hazard
    next(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk); chk("x0_no_haz", 32'(got[0]), 32'b11000);
    next(); idle(); ex_mem_read = 1; ex_rd = 6; id_rs2 = 6; id_use_rs2 = 0;
    @(negedge clk); chk("unused_rs2", 32'(got[0]), 32'b11000);

    // Taken branch: two flush cycles, then RUN
    next(); idle(); ex_br_taken = 1;     @(negedge clk); chk("br_cyc0", 32'(got[0]), 32'b11110);
    next(); idle();                      @(negedge clk); chk("br_cyc1", 32'(got[0]), 32'b11110);
    next();                              @(negedge clk); chk("br_done", 32'(got[0]), 32'b11000);

    // Memory wait for 3 cycles with a pending load-use
    for (int k = 0; k < 3; k++) begin
      next(); idle(); ld_hazard(); mem_req = 1; mem_ack = 0;
      @(negedge clk); chk("mem_wait", 32'(got[0]), 32'b00001);
    end
    next(); mem_ack = 1;                 @(negedge clk); chk("mem_ack_lu", 32'(got[0]), 32'b00010);
    next(); idle();                      @(negedge clk); chk("mem_done", 32'(got[0]), 32'b11000);

    // Branch and load-use together: flush only
    next(); ld_hazard(); ex_br_taken = 1; @(negedge clk); chk("br_lu_0", 32'(got[0]), 32'b11110);
    next(); idle();                      @(negedge clk); chk("br_lu_1", 32'(got[0]), 32'b11110);
    next();                              @(negedge clk); chk("br_lu_2", 32'(got[0]), 32'b11000);

    // Branch aborts a 3-cycle load stall (instance b, 3-cycle flush)
    next(); ld_hazard();                 @(negedge clk); chk("ls_0", 32'(got[1]), 32'b00010);
    next(); idle();                      @(negedge clk); chk("ls_1", 32'(got[1]), 32'b00010);
    next(); ex_br_taken = 1;             @(negedge clk); chk("ls_abort", 32'(got[1]), 32'b11110);
    next(); idle();                      @(negedge clk); chk("ls_fl1", 32'(got[1]), 32'b11110);
    next();                              @(negedge clk); chk("ls_fl2", 32'(got[1]), 32'b11110);
    next();                              @(negedge clk); chk("ls_run", 32'(got[1]), 32'b11000);

    // Reset in the middle of a flush
    next(); ex_br_taken = 1;             @(negedge clk); chk("rb_br", 32'(got[0]), 32'b11110);
    next(); idle(); rst = 1;             @(negedge clk); chk("rb_rst", 32'(got[0]), 32'b00110);
    chk("rb_perf_s", gps[0], 32'd0);
    chk("rb_perf_f", gpf[0], 32'd0);
    next(); rst = 0;                     @(negedge clk); chk("rb_run", 32'(got[0]), 32'b11000);
    next(); ld_hazard();                 @(negedge clk); chk("rb_lu", 32'(got[0]), 32'b00010);
    next(); idle(); ex_br_taken = 1;     @(negedge clk);
    next(); idle();                      @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("perf_s_lit", gps[0], 32'd1);
    chk("perf_f_lit", gpf[0], 32'd1);
`else
    chk("perf_s_lit", gps[0], 32'd0);
    chk("perf_f_lit", gpf[0], 32'd0);
`endif

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      next();
      rst         = ($urandom_range(0, 199) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 99) < 15);
      mem_req     = ($urandom_range(0, 99) < 30);
      mem_ack     = 1'($urandom_range(0, 1));
    end
    next(); idle(); rst = 0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; companion to the forwarding unit.
- Detects the hazards that forwarding cannot resolve and drives the stall, bubble, flush and hold enables of the pipeline registers:
  - load-use
  - taken branch/jump resolved in EX
  - data-memory wait
- Sits in ID/EX control. Its outputs feed the PC register, IF/ID, ID/EX and EX/MEM enables.

Parameters:
- LD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7; >1 for slow data memories).
- BR_FLUSH_CYCLES, 2, IF/ID flush cycles after a taken branch (1..7; covers multi-cycle fetch).
- CNT_W, 3, width of the internal stall/flush down-counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch/jump (PC redirect)
- mem_req  in  1  MEM stage issues a data-memory access this cycle
- mem_ack  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_bubble  out  1  ID/EX load NOP
- ex_mem_hold  out  1  hold EX/MEM and MEM/WB
- perf_stall  out  32  stall-cycle count (optional feature)
- perf_flush  out  32  flush-event count (optional feature)

Behaviour:
- Single clock, clk. Reset is asynchronous and active-high (rst).
- On reset: state=RUN, counter=0, perf counters=0.
- While rst is high, outputs are forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0.
- Outputs are combinational from state plus current inputs. Hazards act in the cycle they are detected.
- Default outputs (RUN, no event): pc_write=1, if_id_write=1, others 0.
- mem_stall = mem_req & ~mem_ack. It has the highest priority in every state. When active:
  - pc_write=0, if_id_write=0, ex_mem_hold=1, if_id_flush=0, id_ex_bubble=0.
  - State and counter are frozen.
  - ex_br_taken and the load-use condition are ignored, because EX is frozen and re-presents them after release.
- On the mem_ack cycle the pipe advances normally.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). x0 never hazards.
- RUN transitions, in priority order after mem_stall:
  - ex_br_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1 (target loaded). If BR_FLUSH_CYCLES>1: counter<=BR_FLUSH_CYCLES-1, go to BR_FLUSH.
  - load_use (no branch): pc_write=0, if_id_write=0, id_ex_bubble=1. If LD_STALL_CYCLES>1: counter<=LD_STALL_CYCLES-1, go to LD_STALL.
  - A branch and a load-use hazard in the same cycle: branch wins. The ID instruction is squashed, so no stall is taken.
- BR_FLUSH state:
  - Outputs: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - Counter decrements each non-frozen cycle. Return to RUN after the cycle in which the counter equals 1.
  - A new ex_br_taken cannot occur here because EX holds bubbles. If it is asserted anyway, it is ignored.
- LD_STALL state:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Counter decrements each non-frozen cycle. Return to RUN after the cycle in which the counter equals 1.
  - An ex_br_taken seen in LD_STALL aborts the stall: apply branch outputs and go to BR_FLUSH (or RUN) exactly as from RUN.
- Reset mid-stall or mid-flush: immediate return to RUN with counter=0. No pending action survives reset.
- The illegal state encoding recovers to RUN on the next clock.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall increments on every cycle where pc_write=0 and rst=0.
  - perf_flush increments once per accepted ex_br_taken.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by rst.
- Undefined: perf_stall and perf_flush are tied to 0 and no counter flops are instantiated.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → the same cycle gives pc_write=0, if_id_write=0, id_ex_bubble=1; with the load moved on, the next cycle returns to defaults.
- x0 and unused source: ex_rd=0 matching id_rs1=0, or match with id_use_rs2=0 on rs2 → no stall; outputs stay at default.
- Taken branch with BR_FLUSH_CYCLES=2: ex_br_taken pulse → if_id_flush=1 for 2 consecutive cycles, pc_write=1 throughout, then RUN.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then ack → ex_mem_hold=1 and pc_write=0 for exactly 3 cycles. A load-use hazard asserted during the wait stalls only after release.
- Branch and load-use in the same cycle → flush taken, no extra stall cycle. A branch during LD_STALL (LD_STALL_CYCLES=3) aborts the stall.
- rst asserted mid BR_FLUSH → outputs forced to reset values immediately, state=RUN after release. With HAZARD_PERF_EN defined, perf_stall and perf_flush equal the counted cycles and events, and are 0 after reset.
